// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the multicycle control FSM and the
// shared-memory RV32I datapath.
//   master : the controller. It receives op/funct3 from the instruction
//            register and mem_ready from memory, and drives every strobe,
//            mux select and status flag.
//   slave  : the datapath/memory side, which has the opposite directions.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       mem_ready;

    logic       mem_req;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCUpdate;
    logic       Branch;
    logic       RegWrite;
    logic       CSRWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ResultSrc;
    logic [1:0] RegWriteSrc;
    logic [2:0] ImmSrc;
    logic [1:0] AccessMode;
    logic       DataExtendMode;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, funct3, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch,
               RegWrite, CSRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
               RegWriteSrc, ImmSrc, AccessMode, DataExtendMode,
               instr_done, illegal
    );

    modport slave (
        output op, funct3, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch,
               RegWrite, CSRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
               RegWriteSrc, ImmSrc, AccessMode, DataExtendMode,
               instr_done, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the RV32I core that shares one memory
// port between instruction fetch and data access. It sequences
// fetch/decode/execute/memory/writeback and generates all datapath strobes.
// Ports:
//   clk   - core clock, rising edge
//   reset - asynchronous, active-high; all outputs are forced to 0 while high
//   bus   - multicycle_ctrl_if.master (op/funct3/mem_ready in, strobes out)
module multicycle_ctrl (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_UPPER, S_CSR, S_TRAP
    } state_t;

    // Per-state Moore outputs. fetch and done_on_ready are qualified with
    // mem_ready outside the register so the handshake strobes fire in the
    // same cycle memory completes.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       fetch;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       csr_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic [1:0] reg_write_src;
        logic       done;
        logic       done_on_ready;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(input state_t s, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_req = 1'b1; c.fetch = 1'b1;
                              c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1;
                              c.done = 1'b1; end
            S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1;
                              c.adr_src = 1'b1; c.done_on_ready = 1'b1; end
            S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                              c.alu_op = 2'b10; end
            S_ALUWB:    begin c.reg_write = 1'b1; c.done = 1'b1; end
            S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01;
                              c.branch = 1'b1; c.done = 1'b1; end
            S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10;
                              c.pc_update = 1'b1; end
            S_UPPER:    begin c.reg_write = 1'b1; c.done = 1'b1;
                              c.reg_write_src = (op == OP_LUI) ? 2'b01 : 2'b10; end
            S_CSR:      begin c.reg_write = 1'b1; c.csr_write = 1'b1;
                              c.reg_write_src = 2'b11; c.done = 1'b1; end
            S_TRAP:     c.illegal = 1'b1;
            default:    ;
        endcase
        return c;
    endfunction

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   w_run;
    logic   w_load;
    logic   w_store;
    logic [2:0] w_imm_src;

    always_comb begin
        w_next = S_TRAP;
        case (r_state)
            S_FETCH:    w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_BR:             w_next = S_BEQ;
                    OP_JAL:            w_next = S_JAL;
                    OP_LUI, OP_AUIPC:  w_next = S_UPPER;
                    OP_SYS:            w_next = S_CSR;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LOAD)
                    w_next = (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                             ? S_MEMREAD : S_TRAP;
                else
                    w_next = (bus.funct3 inside {3'b000, 3'b001, 3'b010})
                             ? S_MEMWRITE : S_TRAP;
            end
            S_MEMREAD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_UPPER:    w_next = S_FETCH;
            S_CSR:      w_next = S_FETCH;
            default:    w_next = S_TRAP;
        endcase
    end

    // Output register is loaded with the outputs of the state being entered,
    // so it always matches r_state. op is stable from DECODE onward, which
    // makes the UPPER lui/auipc select valid when it is captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_for(S_FETCH, OP_LOAD);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next, bus.op);
        end
    end

    assign w_run   = ~reset;
    assign w_load  = (bus.op == OP_LOAD);
    assign w_store = (bus.op == OP_STORE);

    always_comb begin
        w_imm_src = 3'b000;
        case (bus.op)
            OP_STORE:                 w_imm_src = 3'b001;
            OP_BR:                    w_imm_src = 3'b010;
            OP_JAL:                   w_imm_src = 3'b011;
            OP_LUI, OP_AUIPC, OP_SYS: w_imm_src = 3'b100;
            default:                  w_imm_src = 3'b000;
        endcase
    end

    // Every output is gated by reset so the datapath sees no strobe while
    // reset is high, even mid-cycle.
    assign bus.mem_req        = w_run & r_ctrl.mem_req;
    assign bus.MemWrite       = w_run & r_ctrl.mem_write;
    assign bus.AdrSrc         = w_run & r_ctrl.adr_src;
    assign bus.IRWrite        = w_run & r_ctrl.fetch & bus.mem_ready;
    assign bus.PCUpdate       = w_run & (r_ctrl.pc_update | (r_ctrl.fetch & bus.mem_ready));
    assign bus.Branch         = w_run & r_ctrl.branch;
    assign bus.RegWrite       = w_run & r_ctrl.reg_write;
    assign bus.CSRWrite       = w_run & r_ctrl.csr_write;
    assign bus.ALUSrcA        = {2{w_run}} & r_ctrl.alu_src_a;
    assign bus.ALUSrcB        = {2{w_run}} & r_ctrl.alu_src_b;
    assign bus.ALUOp          = {2{w_run}} & r_ctrl.alu_op;
    assign bus.ResultSrc      = {2{w_run}} & r_ctrl.result_src;
    assign bus.RegWriteSrc    = {2{w_run}} & r_ctrl.reg_write_src;
    assign bus.instr_done     = w_run & (r_ctrl.done | (r_ctrl.done_on_ready & bus.mem_ready));
    assign bus.illegal        = w_run & r_ctrl.illegal;
    assign bus.ImmSrc         = {3{w_run}} & w_imm_src;
    assign bus.AccessMode     = (w_run & (w_load | w_store)) ? bus.funct3[1:0] : 2'b00;
    assign bus.DataExtendMode = w_run & w_load & ~bus.funct3[2];
endmodule
